// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                    |
// | Purpose  : Common-data-bus arbiter. Five execution sources (alu0, alu1,   |
// |            alu2, ls, br) each own a one-entry holding slot. One occupied  |
// |            slot is granted per cycle in round-robin order and broadcast   |
// |            through registered outputs for reservation-station wake-up.    |
// | Ports    : clk, rst (async, active low), rdy (global enable), flush       |
// |            <src>_valid/_tag/_data in, <src>_ready out (combinational)     |
// |            cdb_en/cdb_src/cdb_tag/cdb_data registered broadcast           |
// |            err sticky protocol error (valid while ready low)              |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              alu0_valid,
  input  logic [TAG_W-1:0]  alu0_tag,
  input  logic [DATA_W-1:0] alu0_data,
  input  logic              alu1_valid,
  input  logic [TAG_W-1:0]  alu1_tag,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu2_valid,
  input  logic [TAG_W-1:0]  alu2_tag,
  input  logic [DATA_W-1:0] alu2_data,
  input  logic              ls_valid,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_data,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  output logic              alu0_ready,
  output logic              alu1_ready,
  output logic              alu2_ready,
  output logic              ls_ready,
  output logic              br_ready,
  output logic              cdb_en,
  output logic [2:0]        cdb_src,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              err
);

  localparam int       c_NSRC     = 5;
  localparam bit [2:0] c_LAST_RST = 3'd4;  // alu0 gets first priority out of reset

  // Source inputs gathered into index-addressable form (0 alu0 .. 4 br)
  logic [c_NSRC-1:0] w_in_valid;
  logic [TAG_W-1:0]  w_in_tag  [c_NSRC];
  logic [DATA_W-1:0] w_in_data [c_NSRC];

  assign w_in_valid   = {br_valid, ls_valid, alu2_valid, alu1_valid, alu0_valid};
  assign w_in_tag[0]  = alu0_tag;
  assign w_in_tag[1]  = alu1_tag;
  assign w_in_tag[2]  = alu2_tag;
  assign w_in_tag[3]  = ls_tag;
  assign w_in_tag[4]  = br_tag;
  assign w_in_data[0] = alu0_data;
  assign w_in_data[1] = alu1_data;
  assign w_in_data[2] = alu2_data;
  assign w_in_data[3] = ls_data;
  assign w_in_data[4] = br_data;

  // Slot state and broadcast registers
  logic [c_NSRC-1:0] r_v;
  logic [TAG_W-1:0]  r_tag  [c_NSRC];
  logic [DATA_W-1:0] r_data [c_NSRC];
  logic [2:0]        r_last;
  logic              r_cdb_en;
  logic [2:0]        r_cdb_src;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic              r_err;

  logic              w_open;
  logic              w_gnt_any;
  logic [2:0]        w_gnt_idx;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [DATA_W-1:0] w_sel_data;
  logic [c_NSRC-1:0] w_grant;
  logic [c_NSRC-1:0] w_ready;
  logic [c_NSRC-1:0] w_cap;
  logic              w_viol;

  assign w_open = rdy & ~flush;

  // Round-robin pick from registered state only. The first pass looks at
  // slots above the last grant, the second pass wraps to slots at or below
  // it; together they give the search order last+1 .. 4, 0 .. last.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = 3'd0;
    w_sel_tag  = '0;
    w_sel_data = '0;
    if (w_open) begin
      for (int i = 0; i < c_NSRC; i++) begin
        if (!w_gnt_any && r_v[i] && (3'(i) > r_last)) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = 3'(i);
          w_sel_tag  = r_tag[i];
          w_sel_data = r_data[i];
        end
      end
      for (int i = 0; i < c_NSRC; i++) begin
        if (!w_gnt_any && r_v[i] && (3'(i) <= r_last)) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = 3'(i);
          w_sel_tag  = r_tag[i];
          w_sel_data = r_data[i];
        end
      end
    end
  end

  // A slot being drained this cycle may be refilled on the same edge
  for (genvar g = 0; g < c_NSRC; g++) begin : g_slot
    assign w_grant[g] = w_gnt_any & (w_gnt_idx == 3'(g));
    assign w_ready[g] = w_open & (~r_v[g] | w_grant[g]);
    assign w_cap[g]   = w_in_valid[g] & w_ready[g];
  end

  assign w_viol = w_open & (|(w_in_valid & ~w_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v        <= '0;
      r_last     <= c_LAST_RST;
      r_cdb_en   <= 1'b0;
      r_cdb_src  <= 3'd0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < c_NSRC; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        // Pending and outgoing results are discarded; pointer and err keep
        r_v      <= '0;
        r_cdb_en <= 1'b0;
      end else begin
        for (int i = 0; i < c_NSRC; i++) begin
          if (w_cap[i]) begin
            r_v[i]    <= 1'b1;
            r_tag[i]  <= w_in_tag[i];
            r_data[i] <= w_in_data[i];
          end else if (w_grant[i]) begin
            r_v[i] <= 1'b0;
          end
        end
        if (w_gnt_any) begin
          r_last     <= w_gnt_idx;
          r_cdb_en   <= 1'b1;
          r_cdb_src  <= w_gnt_idx;
          r_cdb_tag  <= w_sel_tag;
          r_cdb_data <= w_sel_data;
        end else begin
          r_cdb_en <= 1'b0;
        end
        if (w_viol) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign alu0_ready = w_ready[0];
  assign alu1_ready = w_ready[1];
  assign alu2_ready = w_ready[2];
  assign ls_ready   = w_ready[3];
  assign br_ready   = w_ready[4];
  assign cdb_en     = r_cdb_en;
  assign cdb_src    = r_cdb_src;
  assign cdb_tag    = r_cdb_tag;
  assign cdb_data   = r_cdb_data;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                                 |
// | Purpose  : Self-checking bench for cdb_arbiter: directed vector table,    |
// |            randomized traffic against a reference model, async reset.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;

  typedef struct {
    logic       rdy;
    logic       flush;
    logic [4:0] vm;       // which sources present a result
    logic [4:0] base;     // source i uses tag base+i
    logic [4:0] e_ready;  // ready mask before the edge
    logic       e_en;
    logic [2:0] e_src;
    logic [4:0] e_tag;
    logic       e_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst = 1'b1;
  logic        s_rdy = 1'b1;
  logic        s_flush = 1'b0;
  logic [4:0]  s_valid = '0;
  logic [4:0]  s_tag  [5];
  logic [31:0] s_data [5];

  logic        alu0_ready, alu1_ready, alu2_ready, ls_ready, br_ready;
  logic        cdb_en, err;
  logic [2:0]  cdb_src;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [4:0]  d_ready;

  assign d_ready = {br_ready, ls_ready, alu2_ready, alu1_ready, alu0_ready};

  cdb_arbiter #(.TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(s_rst), .rdy(s_rdy), .flush(s_flush),
    .alu0_valid(s_valid[0]), .alu0_tag(s_tag[0]), .alu0_data(s_data[0]),
    .alu1_valid(s_valid[1]), .alu1_tag(s_tag[1]), .alu1_data(s_data[1]),
    .alu2_valid(s_valid[2]), .alu2_tag(s_tag[2]), .alu2_data(s_data[2]),
    .ls_valid(s_valid[3]),   .ls_tag(s_tag[3]),   .ls_data(s_data[3]),
    .br_valid(s_valid[4]),   .br_tag(s_tag[4]),   .br_data(s_data[4]),
    .alu0_ready(alu0_ready), .alu1_ready(alu1_ready), .alu2_ready(alu2_ready),
    .ls_ready(ls_ready), .br_ready(br_ready),
    .cdb_en(cdb_en), .cdb_src(cdb_src), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: slots as plain arrays, grant found by modular search
  logic        m_v    [5];
  logic [4:0]  m_tag  [5];
  logic [31:0] m_data [5];
  int          m_last;
  logic        m_en;
  logic [2:0]  m_src;
  logic [4:0]  m_otag;
  logic [31:0] m_odata;
  logic        m_err;
  logic [4:0]  m_pre_ready;
  logic [4:0]  pre_ready;
  vec_t        tbl[$];

  function automatic logic [31:0] fdat(input logic [4:0] t, input logic [2:0] s);
    return 32'hDEAD_0000 | {19'd0, t, 8'd0} | {29'd0, s};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_last = 4; m_en = 1'b0; m_src = '0; m_otag = '0; m_odata = '0; m_err = 1'b0;
  endtask

  function automatic int m_grant();
    if (!s_rdy || s_flush) return -1;
    for (int k = 1; k <= 5; k++) begin
      if (m_v[(m_last + k) % 5]) return (m_last + k) % 5;
    end
    return -1;
  endfunction

  function automatic logic [4:0] m_rmask(input int g);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      r[i] = s_rdy && !s_flush && (!m_v[i] || g == i);
    return r;
  endfunction

  task automatic model_edge(input int g);
    if (!s_rdy) return;
    if (s_flush) begin
      for (int i = 0; i < 5; i++) m_v[i] = 1'b0;
      m_en = 1'b0;
      return;
    end
    for (int i = 0; i < 5; i++)
      if (s_valid[i] && !m_pre_ready[i]) m_err = 1'b1;
    if (g >= 0) begin
      m_en = 1'b1; m_src = 3'(g); m_otag = m_tag[g]; m_odata = m_data[g]; m_last = g;
    end else begin
      m_en = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      if (s_valid[i] && m_pre_ready[i]) begin
        m_v[i] = 1'b1; m_tag[i] = s_tag[i]; m_data[i] = s_data[i];
      end else if (g == i) begin
        m_v[i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Inputs are set just after a posedge; ready is sampled after the negedge,
  // registered outputs 1 time unit after the next posedge.
  task automatic cycle();
    int g;
    @(negedge clk); #1;
    pre_ready = d_ready;
    g = m_grant();
    m_pre_ready = m_rmask(g);
    @(posedge clk);
    model_edge(g);
    #1;
    n_vec++;
  endtask

  task automatic set_row(input logic r, input logic f, input logic [4:0] vm, input logic [4:0] base);
    s_rdy = r; s_flush = f; s_valid = vm;
    for (int i = 0; i < 5; i++) begin
      s_tag[i]  = base + 5'(i);
      s_data[i] = fdat(base + 5'(i), 3'(i));
    end
  endtask

  task automatic add(input logic r, input logic f, input logic [4:0] vm, input logic [4:0] base,
                     input logic [4:0] er, input logic en, input logic [2:0] src,
                     input logic [4:0] tg, input logic e);
    vec_t v;
    v.rdy = r; v.flush = f; v.vm = vm; v.base = base; v.e_ready = er;
    v.e_en = en; v.e_src = src; v.e_tag = tg; v.e_err = e;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    set_row(1'b1, 1'b0, 5'b0, 5'd0);
    s_rst = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    chk("rst_en",    32'(cdb_en),   32'd0);
    chk("rst_src",   32'(cdb_src),  32'd0);
    chk("rst_tag",   32'(cdb_tag),  32'd0);
    chk("rst_data",  cdb_data,      32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_ready", 32'(d_ready),  32'h1f);
    s_rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin s_tag[i] = '0; s_data[i] = '0; end
    //    rdy  fl   vm        base   ready     en   src   tag    err
    add(1, 0, 5'b00010, 5'd2,  5'b11111, 0, 3'd0, 5'd0,  0);  // alu1 tag3 captured
    add(1, 0, 5'b00010, 5'd2,  5'b11111, 1, 3'd1, 5'd3,  0);  // streaming alu1
    add(1, 0, 5'b00010, 5'd4,  5'b11111, 1, 3'd1, 5'd3,  0);
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 1, 3'd1, 5'd5,  0);
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 0, 3'd1, 5'd5,  0);  // idle, outputs hold
    add(1, 0, 5'b11111, 5'd1,  5'b11111, 0, 3'd1, 5'd5,  0);  // all five, tags 1..5
    add(1, 0, 5'b00100, 5'd1,  5'b00100, 1, 3'd2, 5'd3,  0);  // round robin from alu2
    add(1, 0, 5'b01000, 5'd1,  5'b01000, 1, 3'd3, 5'd4,  0);
    add(1, 0, 5'b10000, 5'd1,  5'b10000, 1, 3'd4, 5'd5,  0);
    add(1, 0, 5'b00001, 5'd1,  5'b00001, 1, 3'd0, 5'd1,  0);  // wrap to alu0
    add(1, 0, 5'b00000, 5'd0,  5'b00010, 1, 3'd1, 5'd2,  0);
    add(1, 1, 5'b00010, 5'd9,  5'b00000, 0, 3'd1, 5'd2,  0);  // flush with 4 pending
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 0, 3'd1, 5'd2,  0);  // nothing stale
    add(1, 0, 5'b10000, 5'd7,  5'b11111, 0, 3'd1, 5'd2,  0);  // br tag11
    add(1, 0, 5'b01001, 5'd7,  5'b11111, 1, 3'd4, 5'd11, 0);  // alu0 tag7, ls tag10
    add(1, 0, 5'b00000, 5'd0,  5'b10111, 1, 3'd0, 5'd7,  0);  // after br: alu0 first
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 1, 3'd3, 5'd10, 0);  // then ls
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 0, 3'd3, 5'd10, 0);
    add(1, 0, 5'b01000, 5'd0,  5'b11111, 0, 3'd3, 5'd10, 0);  // ls tag3
    add(1, 0, 5'b00001, 5'd6,  5'b11111, 1, 3'd3, 5'd3,  0);  // alu0 tag6
    add(0, 0, 5'b00000, 5'd0,  5'b00000, 1, 3'd3, 5'd3,  0);  // rdy low: frozen
    add(0, 0, 5'b01000, 5'd20, 5'b00000, 1, 3'd3, 5'd3,  0);  // ignored, no err
    add(0, 1, 5'b00000, 5'd0,  5'b00000, 1, 3'd3, 5'd3,  0);  // flush under rdy=0 holds
    add(1, 0, 5'b01010, 5'd8,  5'b11111, 1, 3'd0, 5'd6,  0);  // alu1 tag9, ls tag11
    add(1, 0, 5'b01000, 5'd12, 5'b10111, 1, 3'd1, 5'd9,  1);  // ls valid while not ready
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 1, 3'd3, 5'd11, 1);  // original ls data
    add(1, 0, 5'b00000, 5'd0,  5'b11111, 0, 3'd3, 5'd11, 1);

    #1;
    do_reset();
    set_row(1'b1, 1'b0, 5'b0, 5'd0);
    cycle();
    chk("idle_en", 32'(cdb_en), 32'd0);

    foreach (tbl[r]) begin
      set_row(tbl[r].rdy, tbl[r].flush, tbl[r].vm, tbl[r].base);
      cycle();
      chk($sformatf("row%0d_ready", r), 32'(pre_ready), 32'(tbl[r].e_ready));
      chk($sformatf("row%0d_en",    r), 32'(cdb_en),    32'(tbl[r].e_en));
      chk($sformatf("row%0d_src",   r), 32'(cdb_src),   32'(tbl[r].e_src));
      chk($sformatf("row%0d_tag",   r), 32'(cdb_tag),   32'(tbl[r].e_tag));
      chk($sformatf("row%0d_err",   r), 32'(err),       32'(tbl[r].e_err));
      if (tbl[r].e_en)
        chk($sformatf("row%0d_data", r), cdb_data, fdat(tbl[r].e_tag, tbl[r].e_src));
    end

    // Randomized traffic against the model, with periodic resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] pm;
      if (n % 1000 == 999) do_reset();
      s_rdy   = ($urandom % 8) != 0;
      s_flush = ($urandom % 16) == 0;
      pm = m_rmask(m_grant());
      for (int i = 0; i < 5; i++) begin
        s_valid[i] = ($urandom % 2 == 1) && (pm[i] || ($urandom % 25 == 0));
        s_tag[i]   = 5'($urandom);
        s_data[i]  = $urandom;
      end
      cycle();
      chk("rnd_ready", 32'(pre_ready), 32'(m_pre_ready));
      chk("rnd_en",    32'(cdb_en),    32'(m_en));
      chk("rnd_src",   32'(cdb_src),   32'(m_src));
      chk("rnd_tag",   32'(cdb_tag),   32'(m_otag));
      chk("rnd_data",  cdb_data,       m_odata);
      chk("rnd_err",   32'(err),       32'(m_err));
    end

    // Reset asserted mid-broadcast drops it without waiting for a clock edge
    do_reset();
    set_row(1'b1, 1'b0, 5'b00001, 5'd17);
    cycle();
    set_row(1'b1, 1'b0, 5'b00000, 5'd0);
    cycle();
    chk("bcast_en",  32'(cdb_en),  32'd1);
    chk("bcast_tag", 32'(cdb_tag), 32'd17);
    #2 s_rst = 1'b0;
    #1;
    chk("async_rst_en",  32'(cdb_en),  32'd0);
    chk("async_rst_tag", 32'(cdb_tag), 32'd0);
    s_rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
